// File: rtl/x_micro_sequencer_pkg.sv
// Shared definitions for the micro sequencer and its capture-side recorder.
// Program entries are {data, cmd}; the recorder emits DAT, DEL and END entries.
package x_micro_sequencer_pkg;

  // Entry command codes
  localparam logic [3:0] CMD_DAT = 4'h0;
  localparam logic [3:0] CMD_DEL = 4'h1;
  localparam logic [3:0] CMD_END = 4'h2;

  // Default payload width of a program entry
  localparam int unsigned SEQ_DATA_W = 36;

  typedef struct packed {
    logic [SEQ_DATA_W-1:0] data;
    logic [3:0]            cmd;
  } seq_entry_t;

  // Recorder state encoding
  typedef enum logic [2:0] {
    REC_IDLE = 3'd0,
    REC_ARM  = 3'd1,
    REC_PEND = 3'd2,
    REC_CAP  = 3'd3,
    REC_FIN  = 3'd4
  } rec_state_e;

  // True for commands that carry a bus value rather than control information
  function automatic logic cmd_is_data(input logic [3:0] cmd);
    return (cmd == CMD_DAT);
  endfunction

endpackage

// File: rtl/x_micro_recorder_ram.sv
// Simple dual-port program RAM for the micro recorder.
// One write port, one registered read port; a same-cycle read of the address
// being written returns the previous contents. The array itself is not reset.
module x_micro_recorder_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WIDTH  = 40
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: storage array, deliberately without reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered, holds its value while i_ren is low
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_ren) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/x_micro_recorder.sv
// Micro recorder: samples a bus every cycle and run-length encodes it into a
// program RAM using the sequencer entry format {data, cmd}.
// Optional macro X_MICRO_RECORDER_ARM_EN adds an i_trig input and an ARM state
// that waits for the trigger before capture starts.
module x_micro_recorder
  import x_micro_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEL_W  = 17
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
`ifdef X_MICRO_RECORDER_ARM_EN
  input  logic                i_trig,
`endif
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_busy,
  output logic                o_overflow,
  output logic [ADDR_W:0]     o_count,
  input  logic                i_ren,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W+3:0]   o_rdata
);

  localparam int unsigned ENTRY_W = DATA_W + 4;

  localparam logic [DEL_W-1:0] DEL_MAX = {DEL_W{1'b1}};
  localparam logic [DEL_W-1:0] RUN_ONE = {{(DEL_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  // DEPTH-2: last slot that can take a data/delay entry, leaving room for END
  localparam logic [ADDR_W:0]  FULL_PTR = {1'b0, {(ADDR_W-1){1'b1}}, 1'b0};

  rec_state_e          r_state;
  rec_state_e          w_state_nxt;
  logic [ADDR_W:0]     r_ptr;
  logic [ADDR_W:0]     w_ptr_nxt;
  logic [DEL_W-1:0]    r_run;
  logic [DEL_W-1:0]    w_run_nxt;
  logic [DATA_W-1:0]   r_cur;
  logic [DATA_W-1:0]   w_cur_nxt;
  logic                r_overflow;
  logic                w_overflow_nxt;

  logic                w_we;
  logic [ENTRY_W-1:0]  w_wdata;
  logic                w_full;
  logic                w_stop;
  logic                w_chg;

  function automatic logic [ENTRY_W-1:0] dat_entry(input logic [DATA_W-1:0] v);
    return {v, CMD_DAT};
  endfunction

  function automatic logic [ENTRY_W-1:0] del_entry(input logic [DEL_W-1:0] n);
    return {{(DATA_W-DEL_W){1'b0}}, n, CMD_DEL};
  endfunction

  function automatic logic [ENTRY_W-1:0] end_entry();
    return {{DATA_W{1'b0}}, CMD_END};
  endfunction

  // A full RAM forces the same path as an explicit stop
  assign w_full = (r_ptr == FULL_PTR);
  assign w_stop = i_stop | w_full;
  assign w_chg  = (i_data != r_cur);

  // Next-state, RAM write and counter update for the capture FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_run_nxt      = r_run;
    w_cur_nxt      = r_cur;
    w_overflow_nxt = r_overflow;
    w_we           = 1'b0;
    w_wdata        = end_entry();

    unique case (r_state)
      REC_IDLE: begin
        if (i_start) begin
          w_ptr_nxt      = '0;
          w_overflow_nxt = 1'b0;
`ifdef X_MICRO_RECORDER_ARM_EN
          w_state_nxt    = REC_ARM;
`else
          w_cur_nxt      = i_data;
          w_state_nxt    = REC_PEND;
`endif
        end
      end

`ifdef X_MICRO_RECORDER_ARM_EN
      REC_ARM: begin
        if (i_stop) begin
          w_state_nxt = REC_IDLE;
        end else if (i_trig) begin
          w_cur_nxt   = i_data;
          w_state_nxt = REC_PEND;
        end
      end
`endif

      REC_PEND: begin
        // First cycle of a new value: its DAT entry is always written
        w_we    = 1'b1;
        w_wdata = dat_entry(r_cur);
        if (w_stop) begin
          w_state_nxt = REC_FIN;
          if (!i_stop) begin
            w_overflow_nxt = 1'b1;
          end
        end else if (w_chg) begin
          w_cur_nxt = i_data;
        end else begin
          w_run_nxt   = RUN_ONE;
          w_state_nxt = REC_CAP;
        end
      end

      REC_CAP: begin
        if (w_stop) begin
          w_we        = 1'b1;
          w_wdata     = del_entry(r_run);
          w_state_nxt = REC_FIN;
          if (!i_stop) begin
            w_overflow_nxt = 1'b1;
          end
        end else if (w_chg) begin
          w_we        = 1'b1;
          w_wdata     = del_entry(r_run);
          w_cur_nxt   = i_data;
          w_state_nxt = REC_PEND;
        end else if (r_run == DEL_MAX) begin
          // Counter saturated: flush a full-length delay and keep counting
          w_we      = 1'b1;
          w_wdata   = del_entry(DEL_MAX);
          w_run_nxt = RUN_ONE;
        end else begin
          w_run_nxt = r_run + RUN_ONE;
        end
      end

      REC_FIN: begin
        w_we        = 1'b1;
        w_wdata     = end_entry();
        w_state_nxt = REC_IDLE;
      end

      default: begin
        w_state_nxt = REC_IDLE;
      end
    endcase

    if (w_we) begin
      w_ptr_nxt = r_ptr + PTR_ONE;
    end
  end

  // Recorder state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= REC_IDLE;
      r_ptr      <= '0;
      r_run      <= '0;
      r_cur      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_run      <= w_run_nxt;
      r_cur      <= w_cur_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  x_micro_recorder_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_waddr (r_ptr[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_ren   (i_ren),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata)
  );

  assign o_busy     = (r_state != REC_IDLE);
  assign o_overflow = r_overflow;
  assign o_count    = r_ptr;

endmodule
